// File: rtl/cpu_axi_pkg.sv
// Shared types and AXI4 read constants for the CPU-side AXI bridges.
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         LINE_WORDS = 8;

endpackage

// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read address + read data channels; master = bridge, slave = memory side.
interface icache_axi_rd_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/icache_axi_rd_bridge_line_buffer.sv
// Cache-line assembly registers: one word written per accepted beat, async clear.
module line_buffer
  import cpu_axi_pkg::*;
#(
  parameter int WORDS = LINE_WORDS,
  parameter int IDX_W = $clog2(LINE_WORDS)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [31:0]            wdata,
  output logic [WORDS-1:0][31:0] line
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      line <= '0;
    end else if (we) begin
      line[idx] <= wdata;
    end
  end

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// ICache line-fill responder: one 8-beat AXI4 INCR burst per request, mem_gnt pulse when the line is whole.
// Latency: request sampled in IDLE -> arvalid next cycle -> grant one cycle after the last beat (>=10 cycles).
module icache_axi_rd_bridge
  import cpu_axi_pkg::*;
#(
  parameter int         OFFSET_LEN = 5,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  mem_read_req,
  input  logic [31:0]                           mem_addr,
  output logic                                  mem_gnt,
  output logic [(1<<(OFFSET_LEN-2))-1:0][31:0]  ins,
  output logic                                  bus_err,
  icache_axi_rd_bridge_if.master                axi
);

  localparam int WORDS = 1 << (OFFSET_LEN - 2);
  localparam int IDX_W = OFFSET_LEN - 2;

  bridge_state_t   state;
  logic [31:0]     araddr_q;
  logic [IDX_W-1:0] cnt;
  logic            beat;
  logic            last_idx;
  logic            unused_ok;

  // rready is asserted for the whole of RD, so a beat is simply rvalid in RD.
  assign beat     = (state == RD) && axi.rvalid;
  assign last_idx = (cnt == IDX_W'(WORDS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      araddr_q <= '0;
      cnt      <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read_req) begin
            araddr_q <= {mem_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
            state    <= AR;
          end
        end
        AR: begin
          if (axi.arready) begin
            cnt   <= '0;
            state <= RD;
          end
        end
        RD: begin
          if (axi.rvalid) begin
            cnt <= cnt + 1'b1;
            // Length is fixed at 8 beats; a misplaced rlast is flagged, never obeyed.
            if ((axi.rresp != RESP_OKAY) || (axi.rlast != last_idx)) begin
              bus_err <= 1'b1;
            end
            if (last_idx) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  line_buffer #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_line_buffer (
    .clk    (clk),
    .resetn (resetn),
    .we     (beat),
    .idx    (cnt),
    .wdata  (axi.rdata),
    .line   (ins)
  );

  assign mem_gnt     = (state == DONE);
  assign axi.arvalid = (state == AR);
  assign axi.rready  = (state == RD);
  assign axi.araddr  = araddr_q;
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'(WORDS - 1);
  assign axi.arsize  = SIZE_WORD;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  assign unused_ok = ^{mem_addr[OFFSET_LEN-1:0], axi.rid};

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Randomised line fills against a queue-based line/address model; a negedge monitor scores AR and grants.
module tb_icache_axi_rd_bridge;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             mem_read_req = 1'b0;
  logic [31:0]      mem_addr = '0;
  logic             mem_gnt;
  logic [7:0][31:0] ins;
  logic             bus_err;

  icache_axi_rd_bridge_if axi();

  icache_axi_rd_bridge #(
    .OFFSET_LEN (5),
    .AXI_ID     (4'd0)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_read_req (mem_read_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .ins          (ins),
    .bus_err      (bus_err),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] line;
    logic         err;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ar[$];
  exp_t        exp_line[$];
  logic        err_model = 1'b0;
  logic        hold_valid = 1'b0;
  logic [255:0] hold_line = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scores every AR beat and every grant against what stimulus queued.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      hold_valid = 1'b0;
    end else begin
      if (axi.arvalid) begin
        if (exp_ar.size() == 0) begin
          chk("ar_unexpected", 1, 0);
        end else begin
          chk("araddr", axi.araddr, exp_ar[0]);
          chk("ar_const", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
              {4'd0, 8'd7, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
          if (axi.arready) void'(exp_ar.pop_front());
        end
      end
      if (hold_valid) begin
        chk("ins_hold", ins, hold_line);
        if (axi.rvalid && axi.rready) hold_valid = 1'b0;
      end
      if (mem_gnt) begin
        if (exp_line.size() == 0) begin
          chk("gnt_unexpected", 1, 0);
        end else begin
          e = exp_line.pop_front();
          chk("ins_line", ins, e.line);
          chk("bus_err", bus_err, e.err);
          hold_line  = e.line;
          hold_valid = 1'b1;
        end
      end
    end
  end

  // One line fill, acting as both the cache (request) and the AXI slave (AR/R).
  // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic fill(input logic [31:0] addr, input int stall, input int gap, input int err_beat,
                      input int last_beat, input logic [31:0] dbase, input bit keep_req,
                      input int abort_after, input int exp_gnt);
    logic [31:0] w[8];
    logic [1:0]  rs[8];
    logic        rl[8];
    exp_t        e;
    int k, beat, ar_seen, hs, last_cyc;
    bit done, aborted, v;
    for (int i = 0; i < 8; i++) begin
      w[i]  = (dbase != 0) ? dbase + i : $urandom;
      rs[i] = (i == err_beat) ? 2'b10 : 2'b00;
      rl[i] = (i == last_beat);
      e.line[i*32 +: 32] = w[i];
    end
    err_model = err_model | (err_beat >= 0) | (last_beat != 7);
    e.err = err_model;
    exp_ar.push_back(addr & 32'hFFFF_FFE0);
    exp_line.push_back(e);
    mem_read_req = 1'b1;
    mem_addr     = addr;
    k = 0; beat = 0; ar_seen = 0; hs = 0; last_cyc = -100; done = 0; aborted = 0;
    while (!done && k < 200) begin
      axi.arready = (ar_seen >= stall);
      if (hs > 0 && beat < 8) begin
        case (gap)
          0:       v = 1'b1;
          1:       v = (k % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        axi.rvalid = v;
        axi.rdata  = w[beat];
        axi.rresp  = rs[beat];
        axi.rlast  = rl[beat];
      end else begin
        axi.rvalid = 1'b0;
      end
      @(negedge clk);
      if (axi.arvalid) begin
        ar_seen++;
        if (axi.arready) hs++;
      end
      if (axi.rvalid && axi.rready) begin
        beat++;
        if (beat == 8) last_cyc = k;
      end
      if (mem_gnt) begin
        done = 1;
        chk("gnt_after_last_beat", k, last_cyc + 1);
        chk("ar_handshakes", hs, 1);
        if (exp_gnt >= 0) chk("gnt_cycle", k, exp_gnt);
      end
      @(posedge clk);
      #1;
      k++;
      if (!done && abort_after > 0 && beat == abort_after) begin
        resetn       = 1'b0;
        mem_read_req = 1'b0;
        axi.rvalid   = 1'b0;
        axi.arready  = 1'b0;
        #1;
        chk("rst_ctrl", {axi.arvalid, axi.rready, mem_gnt, bus_err}, 4'b0000);
        chk("rst_ins", ins, '0);
        chk("rst_araddr", axi.araddr, 32'h0);
        exp_ar.delete();
        exp_line.delete();
        err_model = 1'b0;
        done = 1;
        aborted = 1;
      end
    end
    if (!done) chk("fill_timeout", 0, 1);
    axi.rvalid  = 1'b0;
    axi.arready = 1'b0;
    if (!keep_req || aborted) mem_read_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit keep;
    axi.arready = 1'b0;
    axi.rid     = 4'd0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rvalid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {mem_gnt, axi.arvalid, axi.rready, bus_err}, 4'b0000);
    chk("reset_araddr", axi.araddr, 32'h0);
    chk("reset_ins", ins, '0);
    resetn = 1'b1;
    idle(1);

    fill(32'hBFC0_0024, 0, 0, -1, 7, 32'h0000_1000, 0, -1, 10);
    idle(2);
    fill(32'h8000_0100, 5, 0, -1, 7, 32'h0, 0, -1, 15);
    idle(2);
    fill($urandom, 0, 1, -1, 7, 32'h0, 0, -1, -1);
    idle(3);
    fill(32'hBFC0_0040, 0, 0, -1, 7, 32'h0, 1, -1, -1);
    fill(32'h0000_1040, 2, 2, -1, 7, 32'h0, 0, -1, -1);
    idle(2);
    for (int i = 0; i < 5; i++) begin
      keep = 1'($urandom_range(0, 1));
      fill($urandom, $urandom_range(0, 3), $urandom_range(0, 2), -1, 7, 32'h0, keep, -1, -1);
      if (!keep) idle($urandom_range(1, 3));
    end

    fill(32'h0000_2000, 0, 0, 3, 7, 32'h0, 0, -1, -1);
    idle(2);
    fill(32'h0000_2020, 1, 1, -1, 5, 32'h0, 0, -1, -1);
    idle(2);
    fill($urandom, 0, 2, -1, 7, 32'h0, 0, -1, -1);
    idle(2);

    fill(32'h0000_3000, 0, 0, -1, 7, 32'h0, 0, 4, -1);
    idle(2);
    resetn = 1'b1;
    idle(1);
    fill(32'h0000_3000, 0, 0, -1, 7, 32'h0000_5000, 0, -1, 10);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Responder for the instruction cache line-fill port.
- Accepts the cache's line request (mem_read_req/mem_addr) and issues one 8-beat AXI4 INCR read burst.
- Assembles the returned words into a line buffer and pulses mem_gnt once, when the whole line is ready.
- Sits between the ICache and the CPU's AXI read channel.

Parameters:
- OFFSET_LEN, 5, byte-offset bits per line; the line holds 1<<(OFFSET_LEN-2) words (8).
- AXI_ID, 4'd0, value driven on arid.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- mem_read_req  in  1  line-fill request, held high by the cache until mem_gnt
- mem_addr  in  32  line address; low OFFSET_LEN bits are 0
- mem_gnt  out  1  one-cycle pulse: line in ins is complete
- ins  out  8x32  line words; word i = address base+4i
- bus_err  out  1  sticky: a burst returned rresp!=OKAY or a mismatched rlast
- arid  out  4  = AXI_ID
- araddr  out  32  latched line address
- arlen  out  8  constant 7
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arlock/arcache/arprot  out  2/4/3  constant 0
- arvalid  out  1  address valid
- arready  in  1
- rid  in  4  ignored
- rdata  in  32
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1

Behaviour:

Reset (resetn=0, asynchronous):
- State IDLE.
- mem_gnt, arvalid, rready, bus_err = 0; araddr = 0; beat counter = 0; ins all 0.

States:
- IDLE:
  - If mem_read_req=1: latch araddr = {mem_addr[31:OFFSET_LEN], 0}, go to AR.
- AR:
  - arvalid=1; araddr stable.
  - On arvalid&&arready: go to RD, beat counter = 0.
- RD:
  - rready=1.
  - Each rvalid&&rready: ins[cnt] <= rdata, cnt++ (3-bit).
  - If rresp!=0: set bus_err; the beat is still stored.
  - On the beat with cnt==7: go to DONE.
  - rlast is checked: rlast asserted at cnt<7, or absent at cnt==7, sets bus_err.
  - The burst always completes at 8 beats; an early rlast does not truncate it.
- DONE:
  - mem_gnt=1 for exactly this cycle; ins holds the full line.
  - Return to IDLE unconditionally.

Handshake rules:
- ins is registered and stays unchanged from DONE until the first beat of the next burst. The cache writes its banks in the cycle after mem_gnt, so it must read a stable line then.
- mem_read_req is sampled only in IDLE. Changes of mem_addr/mem_read_req in AR/RD/DONE are ignored.
- The cache drops mem_read_req the cycle after mem_gnt, so IDLE re-arms without edge detection.
- A request still high in the cycle after DONE starts a new burst. This is legal: it is the next miss.
- arvalid never deasserts before arready. No second AR is issued while a burst is outstanding.
- rvalid gaps: the counter holds and rready stays 1.

Latency:
- Request seen at edge 0 → arvalid in cycle 1.
- With zero-wait AXI: beats accepted in cycles 2-9, mem_gnt in cycle 10.
- Minimum 10 cycles request-to-grant.

Reset mid-burst:
- Immediate return to IDLE with all outputs at reset values.
- The bridge does not drain or track outstanding beats. A system reset resets the AXI slave too.

bus_err:
- Cleared only by reset.
- Does not block mem_gnt.

Decomposition:
- Shared package cpu_axi_pkg holds:
  - bridge_state_t enum {IDLE, AR, RD, DONE}
  - AXI constants: BURST_INCR=2'b01, SIZE_WORD=3'b010, RESP_OKAY=2'b00
  - LINE_WORDS=8
- One natural sub-module: line_buffer (8x32 registers, write enable, 3-bit index, async active-low clear).
- FSM and AXI signalling stay in the top module.

Test Plan:
1. Zero-wait fill:
   - Stimulus: mem_addr=0xBFC0_0024 (low bits nonzero), arready=1, rvalid=1 every cycle, rdata=0x1000+i, rlast on beat 7.
   - Required: araddr=0xBFC0_0020, arlen=7, mem_gnt exactly at cycle 10, ins[i]=0x1000+i, bus_err=0.
2. Stalled AR:
   - Stimulus: arready low for 5 cycles.
   - Required: arvalid and araddr held stable for all 5 cycles, exactly one AR handshake, mem_gnt at cycle 15.
3. Gapped R:
   - Stimulus: rvalid toggles 1,0,1,0…
   - Required: ins correct, mem_gnt one cycle after the 8th accepted beat, no duplicate or skipped words.
4. Error response:
   - Stimulus: beat 3 has rresp=2'b10; a second burst has rlast on beat 5.
   - Required: bus_err=1 and staying 1; both bursts still grant after 8 beats.
5. Back-to-back:
   - Stimulus: req held the cycle after mem_gnt with mem_addr=0x0000_1040.
   - Required: new AR with araddr=0x1040; previous ins values unchanged until the first beat of the new burst.
6. Reset mid-burst:
   - Stimulus: resetn=0 after beat 4.
   - Required: arvalid/rready/mem_gnt=0 immediately, ins=0; a fresh request afterwards completes normally.
